// File: rtl/booth_radix4_multiplier.sv
// Sequential radix-4 (modified Booth) multiplier, signed/unsigned per operation, start/busy/done handshake.
// Optional macro BOOTH_ZERO_SKIP_EN: a zero operand finishes in a single cycle with product 0.
module booth_radix4_multiplier #(
    parameter int N = 16,
    localparam int CW = $clog2(N/2+2)
) (
    input  logic           clock,
    input  logic           resetN,
    input  logic           start,
    input  logic           signedMode,
    input  logic [N-1:0]   dataInM,
    input  logic [N-1:0]   dataInQ,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int W = N + 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CW-1:0] ITER_SIGNED   = CW'(N/2);
    localparam logic [CW-1:0] ITER_UNSIGNED = CW'(N/2 + 1);

    logic [1:0]     state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   q_q, q_d;
    logic           qm1_q, qm1_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   m_q, m_d;
    logic           mode_q, mode_d;
    logic [2*N-1:0] prod_q, prod_d;

    logic [W:0]     m_ext, m_dbl, addend, sum_s;
    logic [W-1:0]   m_load, q_load;
    logic           zero_op;

    assign m_load = signedMode ? {{2{dataInM[N-1]}}, dataInM} : {2'b00, dataInM};
    assign q_load = signedMode ? {{2{dataInQ[N-1]}}, dataInQ} : {2'b00, dataInQ};

`ifdef BOOTH_ZERO_SKIP_EN
    assign zero_op = (dataInM == '0) || (dataInQ == '0);
`else
    assign zero_op = 1'b0;
`endif

    // Booth digit selection and partial-product add, one extra bit so 2M never overflows.
    always_comb begin
        m_ext = {m_q[W-1], m_q};
        m_dbl = {m_q, 1'b0};
        case ({q_q[1:0], qm1_q})
            3'b001, 3'b010: addend = m_ext;
            3'b011:         addend = m_dbl;
            3'b100:         addend = -m_dbl;
            3'b101, 3'b110: addend = -m_ext;
            default:        addend = '0;
        endcase
        sum_s = {a_q[W-1], a_q} + addend;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        mode_d  = mode_q;
        prod_d  = prod_q;
        case (state_q)
            ST_RUN: begin
                if (cnt_q != '0) begin
                    a_d   = {sum_s[W], sum_s[W:2]};
                    q_d   = {sum_s[1:0], q_q[W-1:2]};
                    qm1_d = q_q[1];
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    // Signed runs leave the two extension bits unconsumed at the bottom of Q.
                    prod_d  = mode_q ? {a_q[N-1:0], q_q[W-1:2]} : {a_q[N-3:0], q_q};
                    state_d = ST_DONE;
                end
            end
            default: begin
                if (start) begin
                    m_d     = m_load;
                    q_d     = zero_op ? '0 : q_load;
                    a_d     = '0;
                    qm1_d   = 1'b0;
                    mode_d  = signedMode;
                    cnt_d   = zero_op ? '0 : (signedMode ? ITER_SIGNED : ITER_UNSIGNED);
                    prod_d  = '0;
                    state_d = ST_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            m_q     <= '0;
            mode_q  <= 1'b0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            mode_q  <= mode_d;
            prod_q  <= prod_d;
        end
    end

    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
    assign product = prod_q;

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// Self-checking bench for booth_radix4_multiplier (N=16): directed table, handshake corner cases, random ops.
module tb_booth_radix4_multiplier;

    logic        clock = 1'b0;
    logic        resetN = 1'b0;
    logic        start = 1'b0;
    logic        signedMode = 1'b0;
    logic [15:0] dataInM = '0;
    logic [15:0] dataInQ = '0;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int checks = 0;
    int errors = 0;

    booth_radix4_multiplier #(.N(16)) dut (
        .clock(clock), .resetN(resetN), .start(start), .signedMode(signedMode),
        .dataInM(dataInM), .dataInQ(dataInQ), .busy(busy), .done(done), .product(product)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] m;
        logic [15:0] q;
        bit          md;
        logic [31:0] p;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [15:0] m, input logic [15:0] q, input bit md);
        longint a, b, r;
        a = md ? longint'($signed(m)) : longint'({48'b0, m});
        b = md ? longint'($signed(q)) : longint'({48'b0, q});
        r = a * b;
        return r[31:0];
    endfunction

    function automatic int exp_lat(input logic [15:0] m, input logic [15:0] q, input bit md);
`ifdef BOOTH_ZERO_SKIP_EN
        if (m == 16'h0 || q == 16'h0) return 1;
`endif
        return md ? 9 : 10;
    endfunction

    // Issues one start, returns the result and the number of edges from the accepting edge to done.
    task automatic do_op(input logic [15:0] m, input logic [15:0] q, input bit md,
                         output logic [31:0] p, output int lat);
        @(negedge clock);
        dataInM = m; dataInQ = q; signedMode = md; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check("done_low_after_start", {63'b0, done}, 64'd0);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
        p = product;
    endtask

    initial begin
        logic [31:0] p, held;
        logic [15:0] rm, rq;
        bit          rmd;
        int          lat;

        tbl[0] = '{16'hABCD, 16'h1234, 1'b1, 32'hFA034FA4};
        tbl[1] = '{16'hABCD, 16'h1234, 1'b0, 32'h0C374FA4};
        tbl[2] = '{16'h8000, 16'h8000, 1'b1, 32'h40000000};
        tbl[3] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001};
        tbl[4] = '{16'h0000, 16'h7FFF, 1'b1, 32'h00000000};
        tbl[5] = '{16'h8000, 16'h7FFF, 1'b1, 32'hC0008000};
        tbl[6] = '{16'hFFFF, 16'h0001, 1'b1, 32'hFFFFFFFF};

        #12;
        check("reset_busy", {63'b0, busy}, 64'd0);
        check("reset_done", {63'b0, done}, 64'd0);
        check("reset_product", {32'b0, product}, 64'd0);
        resetN = 1'b1;

        for (int i = 0; i < 7; i++) begin
            do_op(tbl[i].m, tbl[i].q, tbl[i].md, p, lat);
            check($sformatf("tbl%0d_product", i), {32'b0, p}, {32'b0, tbl[i].p});
            check($sformatf("tbl%0d_latency", i), 64'(lat), 64'(exp_lat(tbl[i].m, tbl[i].q, tbl[i].md)));
            check($sformatf("tbl%0d_busy_in_done", i), {63'b0, busy}, 64'd0);
        end

        // Product held stable while sitting in DONE.
        held = product;
        repeat (3) @(posedge clock);
        #1;
        check("product_held", {32'b0, product}, {32'b0, held});
        check("done_held", {63'b0, done}, 64'd1);

        // A second start three cycles into a run must be ignored.
        @(negedge clock);
        dataInM = 16'h1357; dataInQ = 16'hF00D; signedMode = 1'b1; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check("product_cleared_on_start", {32'b0, product}, 64'd0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("busy_mid_run", {63'b0, busy}, 64'd1);
        dataInM = 16'h2222; dataInQ = 16'h3333; signedMode = 1'b0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
        check("ignored_start_product", {32'b0, product}, {32'b0, model(16'h1357, 16'hF00D, 1'b1)});

        // Start issued from DONE begins the next operation at once.
        do_op(16'h2222, 16'h3333, 1'b0, p, lat);
        check("restart_product", {32'b0, p}, {32'b0, model(16'h2222, 16'h3333, 1'b0)});
        check("restart_latency", 64'(lat), 64'd10);

        // Asynchronous reset mid-run, between clock edges.
        @(negedge clock);
        dataInM = 16'h7FFF; dataInQ = 16'h8001; signedMode = 1'b1; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #3;
        resetN = 1'b0;
        #1;
        check("async_reset_busy", {63'b0, busy}, 64'd0);
        check("async_reset_done", {63'b0, done}, 64'd0);
        check("async_reset_product", {32'b0, product}, 64'd0);
        #1;
        resetN = 1'b1;
        do_op(16'h7FFF, 16'h8001, 1'b1, p, lat);
        check("post_reset_product", {32'b0, p}, {32'b0, model(16'h7FFF, 16'h8001, 1'b1)});
        check("post_reset_latency", 64'(lat), 64'd9);

        for (int i = 0; i < 60; i++) begin
            rm  = (($urandom % 8) == 0) ? 16'h0 : 16'($urandom);
            rq  = (($urandom % 8) == 1) ? 16'h0 : 16'($urandom);
            rmd = 1'($urandom);
            do_op(rm, rq, rmd, p, lat);
            check($sformatf("rand%0d_product m=%h q=%h s=%0d", i, rm, rq, rmd),
                  {32'b0, p}, {32'b0, model(rm, rq, rmd)});
            check($sformatf("rand%0d_latency", i), 64'(lat), 64'(exp_lat(rm, rq, rmd)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
